rsa_stream_ctrl: RTL and testbench

- Byte-stream front end that drives an RSA exponentiation core (C = P^E mod M), i.e. the producer/consumer side of the core's operand/en/eoc/C interface.
- Collects P, E, M and Const from a byte-wide valid/ready input stream, holds `en` high until the core reports `eoc`, then captures C and returns it on a byte-wide valid/ready output stream.
- Sits between the chip-level serial/register interface and the core.

---
 rtl/rsa_stream_ctrl.sv | 138 +++++++++++++
 tb/tb_rsa_stream_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/rsa_stream_ctrl.sv
// Byte-stream front end for an RSA exponentiation core: loads P/E/M/Const LSB-first,
// runs the core until eoc, then streams the result back out LSB-first.
module rsa_stream_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             abort,
    input  logic             in_valid,
    input  logic [7:0]       in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [7:0]       out_data,
    input  logic             out_ready,
    output logic             busy,
    output logic             en,
    output logic [WIDTH-1:0] P,
    output logic [WIDTH-1:0] E,
    output logic [WIDTH-1:0] M,
    output logic [WIDTH-1:0] Const,
    input  logic             eoc,
    input  logic [WIDTH-1:0] C
);

    localparam int unsigned NBYTES = WIDTH / 8;
    localparam int unsigned LW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {StLoad, StRun, StDrain} state_e;

    state_e                 state_q, state_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [1:0]             sel_q, sel_d;
    logic [LW-1:0]          drain_q, drain_d;
    logic                   en_q, en_d;
    logic [3:0][WIDTH-1:0]  ops_q;
    logic [WIDTH-1:0]       shift_q;
    logic                   in_fire, out_fire;

    assign in_ready  = (state_q == StLoad);
    assign out_valid = (state_q == StDrain);
    assign busy      = (state_q == StRun) || (state_q == StDrain);
    assign en        = en_q;
    assign out_data  = shift_q[7:0];
    assign P         = ops_q[0];
    assign E         = ops_q[1];
    assign M         = ops_q[2];
    assign Const     = ops_q[3];
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        sel_d   = sel_q;
        drain_d = drain_q;
        en_d    = en_q;
        unique case (state_q)
            StLoad: begin
                if (in_fire) begin
                    if (lane_q == LW'(NBYTES - 1)) begin
                        lane_d = '0;
                        if (sel_q == 2'd3) begin
                            sel_d   = 2'd0;
                            state_d = StRun;
                            en_d    = 1'b1;
                        end else begin
                            sel_d = sel_q + 2'd1;
                        end
                    end else begin
                        lane_d = lane_q + LW'(1);
                    end
                end
            end
            StRun: begin
                if (eoc) begin
                    en_d    = 1'b0;
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (out_fire) begin
                    if (drain_q == LW'(NBYTES - 1)) begin
                        drain_d = '0;
                        state_d = StLoad;
                    end else begin
                        drain_d = drain_q + LW'(1);
                    end
                end
            end
            default: state_d = StLoad;
        endcase
        // abort outranks any transfer or eoc seen in the same cycle
        if (abort) begin
            state_d = StLoad;
            lane_d  = '0;
            sel_d   = 2'd0;
            drain_d = '0;
            en_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q <= StLoad;
            lane_q  <= '0;
            sel_q   <= 2'd0;
            drain_q <= '0;
            en_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            sel_q   <= sel_d;
            drain_q <= drain_d;
            en_q    <= en_d;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            ops_q   <= '0;
            shift_q <= '0;
        end else if (!abort) begin
            if (in_fire) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (lane_q == LW'(i)) begin
                        ops_q[sel_q][i*8 +: 8] <= in_data;
                    end
                end
            end
            if (state_q == StRun && eoc) begin
                shift_q <= C;
            end else if (out_fire) begin
                shift_q <= shift_q >> 8;
            end
        end
    end

endmodule

// File: tb/tb_rsa_stream_ctrl.sv
// Bench for rsa_stream_ctrl at WIDTH=16: table-driven jobs, a result-byte scoreboard,
// plus abort and asynchronous-reset sequences.
module tb_rsa_stream_ctrl;

    localparam int unsigned WIDTH = 16;

    logic             clk = 1'b0;
    logic             rstb;
    logic             abort;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_ready;
    logic             out_valid;
    logic [7:0]       out_data;
    logic             out_ready;
    logic             busy;
    logic             en;
    logic [WIDTH-1:0] P, E, M, Const;
    logic             eoc;
    logic [WIDTH-1:0] C;

    rsa_stream_ctrl #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rstb      (rstb),
        .abort     (abort),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .en        (en),
        .P         (P),
        .E         (E),
        .M         (M),
        .Const     (Const),
        .eoc       (eoc),
        .C         (C)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [63:0] bytes;   // byte i at bits [8*i +: 8], sent in order i = 0..7
        int          gap_at;  // insert a 3-cycle in_valid gap after this byte index
        logic [15:0] p, e, m, k;
        logic [15:0] res;
        logic [7:0]  pat;     // out_ready per drain cycle (bit c), 1 beyond plen
        int          plen;
    } vec_t;

    vec_t vecs[3];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result-byte scoreboard: compare whenever a byte is offered, pop when it is taken.
    always @(negedge clk) begin
        if (rstb && !abort && out_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL out_unexpected: got byte %h expected no output", out_data);
            end else begin
                if (out_data !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL out_data: got %h expected %h", out_data, exp_q[0]);
                end
                if (out_ready) begin
                    void'(exp_q.pop_front());
                    n_xfer++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic load(input logic [63:0] bytes, input int gap_at);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = bytes[i*8 +: 8];
            if (i == 0) check("in_ready_load", in_ready, 1'b1);
            if (i == 7) check("en_before_last", en, 1'b0);
            @(posedge clk); #1;
            if (i == gap_at) begin
                in_valid = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                end
            end
        end
        in_valid = 1'b0;
        check("en_after_last", en, 1'b1);
        check("in_ready_run", in_ready, 1'b0);
        check("busy_run", busy, 1'b1);
    endtask

    task automatic run_core(input logic [15:0] res);
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("en_hold", en, 1'b1);
        eoc = 1'b1;
        C   = res;
        exp_q.push_back(res[7:0]);
        exp_q.push_back(res[15:8]);
        @(posedge clk); #1;
        eoc = 1'b0;
        C   = 16'h5A5A;
        check("en_after_eoc", en, 1'b0);
        check("out_valid_drain", out_valid, 1'b1);
    endtask

    task automatic drain(input logic [7:0] pat, input int plen);
        n_xfer = 0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c < plen) ? pat[c] : 1'b1;
            @(posedge clk); #1;
            if (in_ready) break;
        end
        out_ready = 1'b0;
        check("drain_xfers", n_xfer, 2);
        check("drain_q_empty", exp_q.size(), 0);
        check("in_ready_after", in_ready, 1'b1);
        check("out_valid_after", out_valid, 1'b0);
        check("busy_after", busy, 1'b0);
    endtask

    initial begin
        vecs[0] = '{64'hF0DE_BC9A_7856_3412, -1, 16'h3412, 16'h7856, 16'hBC9A, 16'hF0DE,
                    16'hBEEF, 8'h00, 0};
        vecs[1] = '{64'hF0DE_BC9A_7856_3412, 3, 16'h3412, 16'h7856, 16'hBC9A, 16'hF0DE,
                    16'hBEEF, 8'h14, 5};
        vecs[2] = '{64'h0807_0605_0403_0201, 1, 16'h0201, 16'h0403, 16'h0605, 16'h0807,
                    16'h1234, 8'h05, 3};

        rstb = 1'b0; abort = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        out_ready = 1'b0; eoc = 1'b0; C = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_en", en, 1'b0);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_data", out_data, 8'h00);
        check("rst_busy", busy, 1'b0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_ops", {P, E}, 32'h0);
        check("rst_ops2", {M, Const}, 32'h0);
        rstb = 1'b1;

        for (int v = 0; v < 3; v++) begin
            load(vecs[v].bytes, vecs[v].gap_at);
            check("P", P, vecs[v].p);
            check("E", E, vecs[v].e);
            check("M", M, vecs[v].m);
            check("Const", Const, vecs[v].k);
            run_core(vecs[v].res);
            check("ops_stable", {P, Const}, {vecs[v].p, vecs[v].k});
            drain(vecs[v].pat, vecs[v].plen);
        end

        // Abort after 5 bytes, colliding with an offered byte; then a fresh load.
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h11 * (i + 1);
            @(posedge clk); #1;
        end
        abort   = 1'b1;
        in_data = 8'h99;
        check("en_abort_cycle", en, 1'b0);
        @(posedge clk); #1;
        abort    = 1'b0;
        in_valid = 1'b0;
        check("en_after_abort", en, 1'b0);
        check("in_ready_after_abort", in_ready, 1'b1);
        load(64'h2211_FFEE_DDCC_BBAA, -1);
        check("abort_P", P, 16'hBBAA);
        check("abort_E", E, 16'hDDCC);
        check("abort_M", M, 16'hFFEE);
        check("abort_Const", Const, 16'h2211);

        // Abort from RUN with a simultaneous eoc: must return to LOAD with no output.
        abort = 1'b1;
        eoc   = 1'b1;
        C     = 16'hDEAD;
        @(posedge clk); #1;
        abort = 1'b0;
        eoc   = 1'b0;
        check("run_abort_en", en, 1'b0);
        check("run_abort_busy", busy, 1'b0);
        check("run_abort_out_valid", out_valid, 1'b0);

        // Asynchronous reset mid-RUN.
        load(vecs[0].bytes, -1);
        repeat (3) @(posedge clk);
        #3;
        rstb = 1'b0;
        #1;
        check("arst_en", en, 1'b0);
        check("arst_busy", busy, 1'b0);
        check("arst_in_ready", in_ready, 1'b1);
        check("arst_PE", {P, E}, 32'h0);
        check("arst_MC", {M, Const}, 32'h0);
        #2;
        rstb = 1'b1;
        @(posedge clk); #1;
        eoc = 1'b1;
        C   = 16'hBEEF;
        @(posedge clk); #1;
        eoc = 1'b0;
        check("arst_eoc_ignored", out_valid, 1'b0);
        @(posedge clk); #1;
        check("arst_still_load", in_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
